// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
// The memory side may hold dmem_ack low for any number of cycles.
interface mem_stage_if #(
    parameter int DW = 32
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, variable-latency load/store/call-push
// over the dmem handshake with an ack timeout, MEM/WB register and ALU-result forwarding.
module mem_stage #(
    parameter int DW          = 32,
    parameter int RW          = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid_i,
    input  logic [DW-1:0] alu_i,
    input  logic [DW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic [DW-1:0] ret_addr_i,
    input  logic [RW-1:0] reg_dest_i,
    input  logic          mem_wr_i,
    input  logic          wb_sel_i,
    input  logic          reg_wr_i,
    input  logic          call_i,
    output logic          stall_o,
    mem_stage_if.master   dmem,
    output logic          fwd_valid_o,
    output logic [DW-1:0] fwd_data_o,
    output logic [RW-1:0] fwd_dest_o,
    output logic          wb_valid_o,
    output logic [DW-1:0] wb_data_o,
    output logic [RW-1:0] wb_dest_o,
    output logic          wb_reg_wr_o,
    output logic          mem_err_o
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          v_q;
    logic [DW-1:0] alu_q, mem_addr_q, mem_data_q, ret_addr_q;
    logic [RW-1:0] dest_q;
    logic          mem_wr_q, wb_sel_q, reg_wr_q, call_q;

    logic          wb_valid_q, wb_reg_wr_q, mem_err_q;
    logic [DW-1:0] wb_data_q;
    logic [RW-1:0] wb_dest_q;

    logic is_write, is_read, access, req, timeout_abort, stall, complete;

    assign is_write      = call_q | mem_wr_q;
    assign is_read       = wb_sel_q & ~is_write;
    assign access        = is_write | is_read;
    assign req           = v_q & access;
    assign timeout_abort = req & (state_q == WAIT) & ~dmem.dmem_ack
                           & (cnt_q >= CW'(ACK_TIMEOUT - 1));
    assign stall         = req & ~dmem.dmem_ack & ~timeout_abort;
    assign complete      = v_q & ~stall;

    assign stall_o          = stall;
    assign dmem.dmem_req    = req;
    assign dmem.dmem_we     = is_write;
    assign dmem.dmem_addr   = mem_addr_q;
    assign dmem.dmem_wdata  = call_q ? ret_addr_q : mem_data_q;

    assign fwd_valid_o = v_q & reg_wr_q & ~is_read & ~call_q;
    assign fwd_data_o  = alu_q;
    assign fwd_dest_o  = dest_q;

    assign wb_valid_o  = wb_valid_q;
    assign wb_data_o   = wb_data_q;
    assign wb_dest_o   = wb_dest_q;
    assign wb_reg_wr_o = wb_reg_wr_q;
    assign mem_err_o   = mem_err_q;

    // The counter includes the initial request cycle, so the first WAIT cycle already sees 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (stall) begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end
            end
            WAIT: begin
                if (!stall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= 1'b0;
            alu_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            ret_addr_q <= '0;
            dest_q     <= '0;
            mem_wr_q   <= 1'b0;
            wb_sel_q   <= 1'b0;
            reg_wr_q   <= 1'b0;
            call_q     <= 1'b0;
        end else if (!stall) begin
            v_q        <= ex_valid_i;
            alu_q      <= alu_i;
            mem_addr_q <= mem_addr_i;
            mem_data_q <= mem_data_i;
            ret_addr_q <= ret_addr_i;
            dest_q     <= reg_dest_i;
            mem_wr_q   <= mem_wr_i;
            wb_sel_q   <= wb_sel_i;
            reg_wr_q   <= reg_wr_i;
            call_q     <= call_i;
        end
    end

    // A timed-out access still retires so the pipeline drains, but never writes the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_dest_q   <= '0;
            wb_reg_wr_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            mem_err_q <= mem_err_q | timeout_abort;
            if (complete) begin
                wb_valid_q  <= 1'b1;
                wb_dest_q   <= dest_q;
                wb_data_q   <= is_read ? dmem.dmem_rdata : alu_q;
                wb_reg_wr_q <= reg_wr_q & ~call_q & ~timeout_abort;
            end else begin
                wb_valid_q  <= 1'b0;
                wb_reg_wr_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected writebacks are queued as instructions
// are issued and popped when wb_valid appears.
module tb_mem_stage;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int AT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          exValid;
    logic [DW-1:0] aluIn, memAddrIn, memDataIn, retAddrIn;
    logic [RW-1:0] regDestIn;
    logic          memWrIn, wbSelIn, regWrIn, callIn;

    logic          stall, fwdValid, wbValid, wbRegWr, memErr;
    logic [DW-1:0] fwdData, wbData;
    logic [RW-1:0] fwdDest, wbDest;

    mem_stage_if #(.DW(DW)) dmem();

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] dest;
        logic          regWr;
    } wbExp_t;

    wbExp_t expQ[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.DW(DW), .RW(RW), .ACK_TIMEOUT(AT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid_i  (exValid),
        .alu_i       (aluIn),
        .mem_addr_i  (memAddrIn),
        .mem_data_i  (memDataIn),
        .ret_addr_i  (retAddrIn),
        .reg_dest_i  (regDestIn),
        .mem_wr_i    (memWrIn),
        .wb_sel_i    (wbSelIn),
        .reg_wr_i    (regWrIn),
        .call_i      (callIn),
        .stall_o     (stall),
        .dmem        (dmem.master),
        .fwd_valid_o (fwdValid),
        .fwd_data_o  (fwdData),
        .fwd_dest_o  (fwdDest),
        .wb_valid_o  (wbValid),
        .wb_data_o   (wbData),
        .wb_dest_o   (wbDest),
        .wb_reg_wr_o (wbRegWr),
        .mem_err_o   (memErr)
    );

    task automatic applyStimulus(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] ret,
                                 input logic [RW-1:0] dest, input logic mw, input logic ws,
                                 input logic rw, input logic cl);
        exValid   = v;
        aluIn     = alu;
        memAddrIn = addr;
        memDataIn = data;
        retAddrIn = ret;
        regDestIn = dest;
        memWrIn   = mw;
        wbSelIn   = ws;
        regWrIn   = rw;
        callIn    = cl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, dmem.dmem_req, dmem.dmem_we, fwdValid, wbValid, wbRegWr, memErr} !== 7'b0)
            begin errors++; $display("[TB] FAIL reset_flags got %b want 0000000",
                {stall, dmem.dmem_req, dmem.dmem_we, fwdValid, wbValid, wbRegWr, memErr}); end
        checks++;
        if ({dmem.dmem_addr, dmem.dmem_wdata, wbData, fwdData, wbDest, fwdDest} !== '0)
            begin errors++; $display("[TB] FAIL reset_buses got %h want 0",
                {dmem.dmem_addr, dmem.dmem_wdata, wbData, fwdData, wbDest, fwdDest}); end
        @(posedge clk) #1;
        rst = 1'b0;
        dmem.dmem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({dmem.dmem_req, wbValid, stall} !== 3'b000)
            begin errors++; $display("[TB] FAIL idle_stray_ack got req/wbv/stall=%b want 000",
                {dmem.dmem_req, wbValid, stall}); end
        @(posedge clk) #1;
        dmem.dmem_ack = 1'b0;
    endtask

    task automatic test_alu();
        wbExp_t e;
        @(posedge clk) #1;
        applyStimulus(1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        expQ.push_back('{32'h1234, 4'd3, 1'b1});
        @(posedge clk) #1;
        exValid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fwdValid, fwdData, fwdDest, stall, dmem.dmem_req} !== {1'b1, 32'h1234, 4'd3, 1'b0, 1'b0})
            begin errors++; $display("[TB] FAIL alu_fwd got v=%b d=%h r=%0d st=%b req=%b want 1 1234 3 0 0",
                fwdValid, fwdData, fwdDest, stall, dmem.dmem_req); end
        @(negedge clk);
        checks++;
        if (!wbValid || expQ.size() == 0)
            begin errors++; $display("[TB] FAIL alu_wb_valid got %b want 1", wbValid); end
        else begin
            e = expQ.pop_front();
            if ({wbData, wbDest, wbRegWr} !== {e.data, e.dest, e.regWr})
                begin errors++; $display("[TB] FAIL alu_wb got %h/%0d/%b want %h/%0d/%b",
                    wbData, wbDest, wbRegWr, e.data, e.dest, e.regWr); end
        end
    endtask

    task automatic test_load();
        wbExp_t e;
        int reqCnt = 0, stallCnt = 0, addrBad = 0, fwdBad = 0;
        @(posedge clk) #1;
        applyStimulus(1'b1, 32'h99, 32'h40, 32'h0, 32'h0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        expQ.push_back('{32'hDEADBEEF, 4'd5, 1'b1});
        @(posedge clk) #1;
        exValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                dmem.dmem_ack   = 1'b1;
                dmem.dmem_rdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            reqCnt   += int'(dmem.dmem_req);
            stallCnt += int'(stall);
            if (dmem.dmem_addr !== 32'h40 || dmem.dmem_we !== 1'b0) addrBad++;
            if (fwdValid !== 1'b0) fwdBad++;
            @(posedge clk) #1;
            dmem.dmem_ack = 1'b0;
        end
        checks++;
        if (reqCnt != 4 || stallCnt != 3)
            begin errors++; $display("[TB] FAIL load_handshake got req=%0d stall=%0d cycles want 4 3",
                reqCnt, stallCnt); end
        checks++;
        if (addrBad != 0 || fwdBad != 0)
            begin errors++; $display("[TB] FAIL load_stable got addrBad=%0d fwdBad=%0d want 0 0",
                addrBad, fwdBad); end
        @(negedge clk);
        checks++;
        if (!wbValid || expQ.size() == 0)
            begin errors++; $display("[TB] FAIL load_wb_valid got %b want 1", wbValid); end
        else begin
            e = expQ.pop_front();
            if ({wbData, wbDest, wbRegWr} !== {e.data, e.dest, e.regWr})
                begin errors++; $display("[TB] FAIL load_wb got %h/%0d/%b want %h/%0d/%b",
                    wbData, wbDest, wbRegWr, e.data, e.dest, e.regWr); end
        end
    endtask

    task automatic test_call();
        wbExp_t e;
        @(posedge clk) #1;
        applyStimulus(1'b1, 32'h55, 32'hFF, 32'h0, 32'h101, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        expQ.push_back('{32'h55, 4'd7, 1'b0});
        @(posedge clk) #1;
        exValid = 1'b0;
        dmem.dmem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_wdata, dmem.dmem_addr, stall, fwdValid}
            !== {1'b1, 1'b1, 32'h101, 32'hFF, 1'b0, 1'b0})
            begin errors++; $display("[TB] FAIL call_push got req=%b we=%b wd=%h a=%h st=%b fwd=%b want 1 1 101 ff 0 0",
                dmem.dmem_req, dmem.dmem_we, dmem.dmem_wdata, dmem.dmem_addr, stall, fwdValid); end
        @(posedge clk) #1;
        dmem.dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (!wbValid || expQ.size() == 0)
            begin errors++; $display("[TB] FAIL call_wb_valid got %b want 1", wbValid); end
        else begin
            e = expQ.pop_front();
            if ({wbData, wbDest, wbRegWr} !== {e.data, e.dest, e.regWr})
                begin errors++; $display("[TB] FAIL call_wb got %h/%0d/%b want %h/%0d/%b",
                    wbData, wbDest, wbRegWr, e.data, e.dest, e.regWr); end
        end
    endtask

    task automatic test_store();
        wbExp_t e;
        @(posedge clk) #1;
        applyStimulus(1'b1, 32'hABCD, 32'h80, 32'hCAFE, 32'h999, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        expQ.push_back('{32'hABCD, 4'd2, 1'b1});
        @(posedge clk) #1;
        exValid = 1'b0;
        dmem.dmem_rdata = 32'h11111111;
        @(negedge clk);
        checks++;
        if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_wdata, dmem.dmem_addr, stall}
            !== {1'b1, 1'b1, 32'hCAFE, 32'h80, 1'b1})
            begin errors++; $display("[TB] FAIL store_req got req=%b we=%b wd=%h a=%h st=%b want 1 1 cafe 80 1",
                dmem.dmem_req, dmem.dmem_we, dmem.dmem_wdata, dmem.dmem_addr, stall); end
        @(posedge clk) #1;
        dmem.dmem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0)
            begin errors++; $display("[TB] FAIL store_ack_stall got %b want 0", stall); end
        @(posedge clk) #1;
        dmem.dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (!wbValid || expQ.size() == 0)
            begin errors++; $display("[TB] FAIL store_wb_valid got %b want 1", wbValid); end
        else begin
            e = expQ.pop_front();
            if ({wbData, wbDest, wbRegWr} !== {e.data, e.dest, e.regWr})
                begin errors++; $display("[TB] FAIL store_wb got %h/%0d/%b want %h/%0d/%b",
                    wbData, wbDest, wbRegWr, e.data, e.dest, e.regWr); end
        end
    endtask

    task automatic test_back_to_back();
        wbExp_t e;
        logic [DW-1:0] opAlu  [3] = '{32'h10, 32'h20, 32'h30};
        logic [RW-1:0] opDest [3] = '{4'd1, 4'd4, 4'd8};
        logic          opLoad [3] = '{1'b0, 1'b1, 1'b0};
        logic          opRegWr[3] = '{1'b1, 1'b1, 1'b0};
        int wbCnt = 0, stallCnt = 0;
        dmem.dmem_rdata = 32'h22222222;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk) #1;
            if (c < 3) begin
                applyStimulus(1'b1, opAlu[c], 32'h44, 32'h0, 32'h0, opDest[c], 1'b0, opLoad[c], opRegWr[c], 1'b0);
                expQ.push_back('{opLoad[c] ? 32'h22222222 : opAlu[c], opDest[c], opRegWr[c]});
            end else begin
                exValid = 1'b0;
            end
            dmem.dmem_ack = (c >= 1 && c <= 3) ? opLoad[c-1] : 1'b0;
            @(negedge clk);
            stallCnt += int'(stall);
            if (wbValid) begin
                wbCnt++;
                checks++;
                if (expQ.size() == 0)
                    begin errors++; $display("[TB] FAIL b2b_wb_extra got wb at cycle %0d want none", c); end
                else begin
                    e = expQ.pop_front();
                    if ({wbData, wbDest, wbRegWr} !== {e.data, e.dest, e.regWr})
                        begin errors++; $display("[TB] FAIL b2b_wb got %h/%0d/%b want %h/%0d/%b",
                            wbData, wbDest, wbRegWr, e.data, e.dest, e.regWr); end
                end
            end
        end
        dmem.dmem_ack = 1'b0;
        checks++;
        if (wbCnt != 3 || stallCnt != 0)
            begin errors++; $display("[TB] FAIL b2b_count got wb=%0d stall=%0d want 3 0", wbCnt, stallCnt); end
    endtask

    task automatic test_timeout();
        wbExp_t e;
        int stallCnt = 0;
        dmem.dmem_rdata = 32'h0BADF00D;
        dmem.dmem_ack   = 1'b0;
        @(posedge clk) #1;
        applyStimulus(1'b1, 32'h66, 32'h60, 32'h0, 32'h0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        expQ.push_back('{32'h0BADF00D, 4'd6, 1'b0});
        @(posedge clk) #1;
        applyStimulus(1'b1, 32'h77, 32'h0, 32'h0, 32'h0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        expQ.push_back('{32'h77, 4'd9, 1'b1});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stallCnt += int'(stall);
            @(posedge clk) #1;
        end
        exValid = 1'b0;
        checks++;
        if (stallCnt != 3)
            begin errors++; $display("[TB] FAIL timeout_stall got %0d cycles want 3", stallCnt); end
        @(negedge clk);
        checks++;
        if (!wbValid || expQ.size() == 0)
            begin errors++; $display("[TB] FAIL timeout_wb_valid got %b want 1", wbValid); end
        else begin
            e = expQ.pop_front();
            if ({wbData, wbDest, wbRegWr} !== {e.data, e.dest, e.regWr})
                begin errors++; $display("[TB] FAIL timeout_wb got %h/%0d/%b want %h/%0d/%b",
                    wbData, wbDest, wbRegWr, e.data, e.dest, e.regWr); end
        end
        checks++;
        if ({memErr, fwdValid, fwdData} !== {1'b1, 1'b1, 32'h77})
            begin errors++; $display("[TB] FAIL timeout_next got err=%b fwd=%b fd=%h want 1 1 77",
                memErr, fwdValid, fwdData); end
        @(negedge clk);
        checks++;
        if (!wbValid || expQ.size() == 0)
            begin errors++; $display("[TB] FAIL after_timeout_wb_valid got %b want 1", wbValid); end
        else begin
            e = expQ.pop_front();
            if ({wbData, wbDest, wbRegWr} !== {e.data, e.dest, e.regWr})
                begin errors++; $display("[TB] FAIL after_timeout_wb got %h/%0d/%b want %h/%0d/%b",
                    wbData, wbDest, wbRegWr, e.data, e.dest, e.regWr); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (memErr !== 1'b1)
            begin errors++; $display("[TB] FAIL mem_err_sticky got %b want 1", memErr); end
    endtask

    task automatic test_reset_mid_wait();
        int wbSeen = 0, reqSeen = 0;
        dmem.dmem_ack = 1'b0;
        @(posedge clk) #1;
        applyStimulus(1'b1, 32'h88, 32'h70, 32'h0, 32'h0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk) #1;
        exValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({dmem.dmem_req, stall} !== 2'b11)
            begin errors++; $display("[TB] FAIL midwait_pending got req/stall=%b want 11", {dmem.dmem_req, stall}); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, stall, fwdValid, wbValid, wbRegWr, memErr, wbData}
            !== '0)
            begin errors++; $display("[TB] FAIL async_reset got req=%b a=%h st=%b wbv=%b err=%b want all 0",
                dmem.dmem_req, dmem.dmem_addr, stall, wbValid, memErr); end
        @(posedge clk) #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wbSeen  += int'(wbValid);
            reqSeen += int'(dmem.dmem_req);
        end
        checks++;
        if (wbSeen != 0 || reqSeen != 0 || expQ.size() != 0)
            begin errors++; $display("[TB] FAIL post_reset_idle got wb=%0d req=%0d pending=%0d want 0 0 0",
                wbSeen, reqSeen, expQ.size()); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_call();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage, directly downstream of the execute stage. It holds the EX/MEM pipeline register and runs load, store and call-push accesses over a variable-latency data-memory handshake. It stalls upstream while an access is outstanding. It feeds the MEM/WB register and returns a forwarding path to the execute stage's rs1/rs2 forward muxes.

Parameters:
DW, 32, data/address width
RW, 4, register-index width
ACK_TIMEOUT, 16, max wait cycles for dmem_ack before error abort (≥1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  execute stage presents a valid instruction
alu_in  in  DW  ALU result
mem_addr_in  in  DW  memory address (ALU or stack pointer, already muxed)
mem_data_in  in  DW  store data
ret_addr_in  in  DW  return address pushed by call
reg_dest_in  in  RW  destination register
mem_wr_in  in  1  store
wb_sel_in  in  1  1 = writeback takes memory read data (load), 0 = ALU result
reg_wr_in  in  1  register write enable
call_in  in  1  call (push ret_addr_in)
stall  out  1  hold the execute stage and everything upstream
dmem_req  out  1  memory request
dmem_we  out  1  request is a write
dmem_addr  out  DW  request address
dmem_wdata  out  DW  write data
dmem_rdata  in  DW  read data, valid with dmem_ack
dmem_ack  in  1  access complete
fwd_valid  out  1  fwd_data/fwd_dest usable by execute forwarding
fwd_data  out  DW  forwarded ALU result
fwd_dest  out  RW  forwarded destination register
wb_valid  out  1  MEM/WB register holds an instruction
wb_data  out  DW  writeback value
wb_dest  out  RW  writeback register
wb_reg_wr  out  1  writeback enable
mem_err  out  1  sticky access-timeout error

Behaviour:
- Reset (async, rst=1): v_q=0, the full EX/MEM register is 0, FSM=IDLE, wait counter=0, mem_err=0, and every output is 0.
- Access classification from EX/MEM register fields: write when call_q|mem_wr_q (call/store wins over load); read when wb_sel_q and not write; otherwise no access.
- EX/MEM capture: when !stall, load the register from the inputs and set v_q=ex_valid. When stall=1, hold the register unchanged.
- FSM states: IDLE and WAIT.
  - IDLE: if v_q and the instruction is an access, drive dmem_req=1 combinationally in the same cycle. If dmem_ack=1 that cycle, the access completes (1-cycle access). Otherwise go to WAIT.
  - WAIT: hold dmem_req=1 with stable addr/we/wdata. On dmem_ack, complete and return to IDLE.
- dmem_addr=mem_addr_q. dmem_we=write. dmem_wdata = call_q ? ret_addr_q : mem_data_q.
- stall = v_q & access & !dmem_ack & !timeout_abort. stall is combinational.
- Wait counter:
  - Clears in IDLE.
  - Increments each WAIT cycle without ack.
  - When the count reaches ACK_TIMEOUT-1 in WAIT with no ack, timeout_abort=1 for that cycle. The instruction completes, mem_err is set (sticky until rst), and the FSM returns to IDLE.
- Completion cycle: a non-access instruction completes in its first cycle in the register. An access completes on its ack or abort cycle. At the closing edge the MEM/WB register loads:
  - wb_valid=1
  - wb_dest=dest_q
  - wb_data = (read ? dmem_rdata : alu_q)
  - wb_reg_wr = reg_wr_q & !call_q & !timeout_abort
- Non-completion edge (stall, or v_q=0): MEM/WB loads wb_valid=0 and wb_reg_wr=0. wb_data and wb_dest hold.
- Latency: a non-access instruction reaches WB 1 cycle after capture. An access reaches WB 1 cycle after its ack cycle.
- Forwarding (combinational from the register): fwd_valid = v_q & reg_wr_q & !read & !call_q. fwd_data=alu_q, fwd_dest=dest_q. Load data is never forwarded from this stage; hazard logic must stall for a load-use.
- dmem_ack while dmem_req=0 is ignored.
- Reset mid-WAIT: the request drops immediately, and the pending instruction is discarded without a WB write.

Test Plan:
- Reset: rst=1 mid-run → all outputs 0 asynchronously, before the next clk edge. After release, dmem_req=0 and wb_valid=0.
- ALU op (alu_in=0x1234, dest=3, reg_wr=1, no access) → fwd_valid=1, fwd_data=0x1234 in the capture cycle. Next cycle wb_valid=1, wb_data=0x1234, wb_dest=3, wb_reg_wr=1. stall stays 0.
- Load (mem_addr_in=0x40, wb_sel=1, dest=5), ack after 3 wait cycles with rdata=0xDEADBEEF → dmem_req high 4 cycles, stall high 3 cycles, addr stable at 0x40. Then wb_data=0xDEADBEEF, wb_dest=5. fwd_valid=0 throughout.
- Call (ret_addr_in=0x101, mem_addr_in=0xFF, call=1, reg_wr=1), same-cycle ack → dmem_we=1, dmem_wdata=0x101, stall never asserted. Next cycle wb_valid=1, wb_reg_wr=0.
- Store with mem_wr=1 and wb_sel=1 → treated as a write (dmem_we=1), and wb_data=alu_in rather than rdata.
- No ack with ACK_TIMEOUT=4 → stall high for exactly 3 cycles, then mem_err=1 and wb_reg_wr=0. The next instruction is accepted in the following cycle, and mem_err stays 1 until rst.
